// File: rtl/safe_state_sequencer_pkg.sv
// Shared state encoding for the safe start/done sequencer.
// Codes above S_DONE are illegal and get recovered to IDLE by the top level.
package safe_state_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic isLegalState(input state_e s);
        return (s <= S_DONE);
    endfunction

endpackage

// File: rtl/safe_state_sequencer_dwell_counter.sv
// Down-counter that times both the ARM and the RUN phases.
// When several controls are raised together, clear wins over load, and load wins over decrement.
module dwell_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (clear_i) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (dec_i) begin
            value_q <= value_q - CNT_W'(1);
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/safe_state_sequencer.sv
// Start/done sequencer: IDLE -> ARM -> RUN (pausable via HOLD) -> DONE.
// Outputs are registered from the next state, so they line up with state_o.
module safe_state_sequencer
    import safe_state_sequencer_pkg::*;
#(
    parameter int unsigned       CNT_W      = 8,
    parameter int unsigned       FLAG_W     = 2,
    parameter int unsigned       ARM_CYCLES = 2,
    parameter logic [FLAG_W-1:0] FLAG_IDLE  = FLAG_W'(0),
    parameter logic [FLAG_W-1:0] FLAG_ARM   = FLAG_W'(1),
    parameter logic [FLAG_W-1:0] FLAG_RUN   = FLAG_W'(2),
    parameter logic [FLAG_W-1:0] FLAG_DONE  = FLAG_W'(3)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   run_len,
    input  logic               pause,
    input  logic               abort,
    input  logic               ack,
    output logic [FLAG_W-1:0]  flag,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [FLAG_W-1:0] flag_q, flag_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              errIllegal_q;
    logic              illegal;

    logic              cntClear, cntLoad, cntDec, cntZero;
    logic [CNT_W-1:0]  cntLoadVal, cntValue;

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cntClear),
        .load_i     (cntLoad),
        .load_val_i (cntLoadVal),
        .dec_i      (cntDec),
        .value_o    (cntValue),
        .zero_o     (cntZero)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        flag_d     = FLAG_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cntClear   = 1'b0;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntDec     = 1'b0;
        illegal    = !isLegalState(state_q);

        if (abort || illegal) begin
            state_d  = S_IDLE;
            cntClear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_ARM;
                        len_d      = run_len;
                        cntLoad    = 1'b1;
                        cntLoadVal = ARM_LOAD;
                    end
                end
                S_ARM: begin
                    if (!cntZero) begin
                        cntDec = 1'b1;
                    end else if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_RUN;
                        cntLoad    = 1'b1;
                        cntLoadVal = len_q - CNT_W'(1);
                    end
                end
                // Pause is checked before the terminal count so the last RUN cycle can still be held.
                S_RUN: begin
                    if (pause) begin
                        state_d = S_HOLD;
                    end else if (cntZero) begin
                        state_d = S_DONE;
                    end else begin
                        cntDec = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        case (state_d)
            S_ARM: begin
                flag_d = FLAG_ARM;
                busy_d = 1'b1;
            end
            S_RUN, S_HOLD: begin
                flag_d = FLAG_RUN;
                busy_d = 1'b1;
            end
            S_DONE: begin
                flag_d = FLAG_DONE;
                done_d = 1'b1;
            end
            default: begin
                flag_d = FLAG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            flag_q       <= FLAG_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            errIllegal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            flag_q       <= flag_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            errIllegal_q <= errIllegal_q | illegal;
        end
    end

    assign flag        = flag_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_illegal = errIllegal_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_safe_state_sequencer.sv
// Testbench for safe_state_sequencer: directed vector table, corner-case sequences,
// then random stimulus against a phase/elapsed-time reference model.
module tb_safe_state_sequencer;
    import safe_state_sequencer_pkg::*;

    localparam int CNT_W  = 8;
    localparam int FLAG_W = 2;
    localparam int ARM    = 2;

    logic              clk = 1'b0;
    logic              rst, start, pause, abort, ack;
    logic [CNT_W-1:0]  runLen;
    logic [FLAG_W-1:0] flag;
    logic              busy, done, errIllegal;
    logic [2:0]        stateO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit rst;
        bit start;
        int runLen;
        bit pause;
        bit abort;
        bit ack;
        int expFlag;
        int expBusy;
        int expDone;
        int expState;
    } vecT;

    vecT vecs[$];

    // Reference model: tracks how many non-held ARM/RUN cycles have elapsed since start.
    bit mActive, mDone, mHeld;
    int mElapsed, mLen;

    safe_state_sequencer #(
        .CNT_W      (CNT_W),
        .FLAG_W     (FLAG_W),
        .ARM_CYCLES (ARM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .run_len     (runLen),
        .pause       (pause),
        .abort       (abort),
        .ack         (ack),
        .flag        (flag),
        .busy        (busy),
        .done        (done),
        .err_illegal (errIllegal),
        .state_o     (stateO)
    );

    always #5 clk = ~clk;

    function automatic vecT mkVec(bit r, bit s, int l, bit p, bit a, bit k,
                                  int f, int b, int d, int st);
        vecT v;
        v.rst = r; v.start = s; v.runLen = l; v.pause = p; v.abort = a; v.ack = k;
        v.expFlag = f; v.expBusy = b; v.expDone = d; v.expState = st;
        return v;
    endfunction

    task automatic applyStimulus(bit r, bit s, int l, bit p, bit a, bit k);
        rst    = r;
        start  = s;
        runLen = CNT_W'(l);
        pause  = p;
        abort  = a;
        ack    = k;
    endtask

    task automatic modelStep();
        if (rst) begin
            mActive = 0; mDone = 0; mHeld = 0; mElapsed = 0; mLen = 0;
        end else if (abort) begin
            mActive = 0; mDone = 0; mHeld = 0;
        end else if (mDone) begin
            if (ack) mDone = 0;
        end else if (!mActive) begin
            if (start) begin
                mActive = 1; mElapsed = 0; mLen = int'(runLen);
            end
        end else if (mHeld) begin
            if (!pause) mHeld = 0;
        end else if (mElapsed >= ARM && pause) begin
            mHeld = 1;
        end else begin
            mElapsed++;
            if (mElapsed >= ARM + mLen) begin
                mActive = 0; mDone = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string label, int f, int b, int d, int st, int e);
        checkOutput({label, ".flag"},  32'(flag),       32'(f));
        checkOutput({label, ".busy"},  32'(busy),       32'(b));
        checkOutput({label, ".done"},  32'(done),       32'(d));
        checkOutput({label, ".state"}, 32'(stateO),     32'(st));
        checkOutput({label, ".err"},   32'(errIllegal), 32'(e));
    endtask

    initial begin
        int doneEdge;
        int expState, expFlag;

        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);

        // rst start len pause abort ack | flag busy done state
        vecs.push_back(mkVec(1,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,4,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,4,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,4,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(0,0,4,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(0,0,4,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(0,0,4,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(0,0,4,0,0,0, 3,0,1,4));
        vecs.push_back(mkVec(0,1,4,0,0,0, 3,0,1,4));
        vecs.push_back(mkVec(0,0,4,0,0,0, 3,0,1,4));
        vecs.push_back(mkVec(0,1,4,0,0,1, 0,0,0,0));
        vecs.push_back(mkVec(0,0,4,0,0,0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,0,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,0,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,0,0,0,0, 3,0,1,4));
        vecs.push_back(mkVec(0,0,0,0,0,1, 0,0,0,0));
        vecs.push_back(mkVec(0,1,3,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,3,0,0,1, 1,1,0,1));
        vecs.push_back(mkVec(0,0,3,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(0,0,3,0,0,1, 2,1,0,2));
        vecs.push_back(mkVec(0,0,3,0,1,0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,3,0,1,0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,5,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,5,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,5,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(0,0,5,1,0,0, 2,1,0,3));
        vecs.push_back(mkVec(0,0,5,1,1,0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,0,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,0,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,0,0,0,0, 3,0,1,4));
        vecs.push_back(mkVec(0,0,0,0,1,0, 0,0,0,0));
        vecs.push_back(mkVec(0,1,6,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,6,0,0,0, 1,1,0,1));
        vecs.push_back(mkVec(0,0,6,0,0,0, 2,1,0,2));
        vecs.push_back(mkVec(1,1,6,0,0,0, 0,0,0,0));
        vecs.push_back(mkVec(0,0,6,0,0,0, 0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].runLen,
                          vecs[i].pause, vecs[i].abort, vecs[i].ack);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].expFlag, vecs[i].expBusy,
                     vecs[i].expDone, vecs[i].expState, 0);
        end

        // Pause sampled high on edges 4..6 after start; leaving HOLD resumes with cnt unchanged,
        // so four non-advancing edges push the first DONE from edge 7 to edge 11.
        applyStimulus(0, 1, 4, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 4, 0, 0, 0);
        doneEdge = 0;
        for (int e = 2; e <= 40 && doneEdge == 0; e++) begin
            pause = (e >= 4 && e <= 6);
            tick();
            if (e >= 4 && e <= 6) begin
                checkOutput($sformatf("hold%0d.state", e), 32'(stateO), 32'd3);
                checkOutput($sformatf("hold%0d.cnt", e), 32'(dut.cntValue), 32'd3);
            end
            if (done) doneEdge = e;
        end
        pause = 1'b0;
        checkOutput("pause.doneEdge", 32'(doneEdge), 32'd11);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkAll("pause.ack", 0, 0, 0, 0, 0);

        // Illegal state code: recover to IDLE and raise the sticky error.
        applyStimulus(0, 0, 0, 0, 0, 0);
        force dut.state_q = state_e'(3'd6);
        #1;
        checkOutput("illegal.forced", 32'(stateO), 32'd6);
        @(posedge clk);
        #1;
        release dut.state_q;
        checkOutput("illegal.err",  32'(errIllegal), 32'd1);
        checkOutput("illegal.flag", 32'(flag),       32'd0);
        checkOutput("illegal.busy", 32'(busy),       32'd0);
        @(negedge clk);
        tick();
        checkAll("illegal.recover", 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 0);
        tick();
        checkAll("illegal.sticky", 1, 1, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        checkAll("illegal.rstClr", 0, 0, 0, 0, 0);

        // Random stimulus against the reference model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 9)),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 3) == 0));
            tick();
            if (mDone)         expState = 4;
            else if (!mActive) expState = 0;
            else if (mHeld)    expState = 3;
            else if (mElapsed < ARM) expState = 1;
            else               expState = 2;
            case (expState)
                1:       expFlag = 1;
                2, 3:    expFlag = 2;
                4:       expFlag = 3;
                default: expFlag = 0;
            endcase
            checkAll($sformatf("rnd%0d", c), expFlag, int'(mActive), int'(mDone), expState, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
